key_mix: RTL
============

// Module: key_mix
// PURPOSE
//  RC5 key-schedule mixing stage, directly downstream of the L (key-word) conversion stage.
//  Once the L array has been built, it runs 3*max(T,C) mixing iterations over the S table and the L array.
//  Both live in external synchronous RAMs.
//  Each iteration computes A=S[i]=(S[i]+A+B)<<<3 and B=L[j]=(L[j]+A+B)<<<(A+B), then advances i and j.
//  It then signals completion to the encrypt/decrypt datapath.
// PARAMETERS
//  W  32  word width in bits (power of 2, >=8)
//  C  4   number of L words (>=2)
//  R  12  round count; T=2*(R+1) S words (local, 26 by default)
//  N  local = 3*max(T,C) mixing iterations (78 by default)
// PORTS
//  clk        in   1            system clock, all logic on rising edge
//  rst        in   1            synchronous, active-high reset
//  start      in   1            level; high = L array complete (driven by L-stage done)
//  S_address  out  clog2(T)     S RAM address
//  S_rdata    in   W            S RAM read data
//  S_wdata    out  W            S RAM write data
//  S_we       out  1            S RAM write enable
//  L_address  out  clog2(C)     L RAM address
//  L_rdata    in   W            L RAM read data
//  L_wdata    out  W            L RAM write data
//  L_we       out  1            L RAM write enable
//  done       out  1            mixing finished, S table valid
// BEHAVIOUR
//  - Reset: the following are all 0:
//    - all outputs;
//    - A, B, i, j, k;
//    - state IDLE.
//  - Registers: all outputs are registered; reset applies on the clock edge only.
//  - RAM timing: the RAM returns read data one cycle after the address is registered.
//    Read data must be held stable while the address is unchanged.
//  - FSM states: IDLE, FETCH, WAIT, CALC_A, CALC_B, UPDATE, DONE.
//  - IDLE: stays in IDLE while start=0. Leaves for FETCH when start=1; start is sampled only here.
//  - FETCH: S_address<=i, L_address<=j, S_we<=0, L_we<=0. Next state is WAIT.
//  - WAIT: capture S_rdata->s_val and L_rdata->l_val at the end of the cycle. Next state is CALC_A.
//  - CALC_A:
//    - A<=rotl(s_val+A+B,3); S_wdata<=same value; S_we<=1.
//    - Next state is CALC_B.
//  - CALC_B:
//    - S_we<=0.
//    - B<=rotl(l_val+A_new+B, (A_new+B)[clog2(W)-1:0]); L_wdata<=same value; L_we<=1.
//    - Next state is UPDATE.
//  - UPDATE:
//    - L_we<=0.
//    - i<=(i==T-1)?0:i+1; j<=(j==C-1)?0:j+1; k<=k+1.
//    - If k==N-1: next state is DONE and done<=1. Otherwise next state is FETCH.
//  - DONE: holds with done=1 and both we low; start is ignored. Only rst leaves DONE.
//  - Write pulses: S_we and L_we are each high for exactly 1 cycle per iteration.
//    The address during the pulse equals the i or j of that iteration.
//  - Latency: 5 cycles per iteration.
//    done rises exactly 5*N cycles after the edge that sampled start=1 in IDLE (390 by default).
//  - Arithmetic: all additions are modulo 2^W, no carry out.
//    The rotate amount is the low clog2(W) bits; rotate by 0 is identity.
//  - Wrap-around: i and j wrap independently, and wrap correctly when T!=C.
//  - start dropping mid-run has no effect.
//  - Reset mid-operation: on the next edge, we=0 and done=0, state IDLE, A=B=i=j=k=0.
//    No further writes occur; a new start reruns from i=j=0.
// TESTING
//  1. Reset with start=0 for 10 cycles -> all outputs 0, no writes.
//  2. W=32,R=0,C=2 (T=2,N=6), S and L RAMs all 0, start=1 -> every write data is 0.
//     done rises exactly 30 cycles after the start edge.
//  3. Same parameters, S[0]=1, rest 0:
//     first S write is addr 0, data 0x00000008; first L write is addr 0, data 0x00000800.
//  4. Defaults, S loaded with P/Q init, L from known key:
//     final S RAM matches the C golden model word for word; done at cycle 390.
//     Exactly 78 S_we and 78 L_we pulses.
//  5. Assert rst at iteration 40 during CALC_B -> next cycle we=0, done=0, state IDLE.
//     Re-start -> correct full result from a freshly reloaded RAM.
//  6. T!=C check (R=1,C=3: T=4,N=12) -> i sequence 0,1,2,3,0..; j sequence 0,1,2,0..
//     Final contents match the golden model.

Source files
------------

// File: rtl/key_mix.sv
// RC5 key-schedule mixing stage: runs 3*max(T,C) read-modify-write iterations
// over the external S table and L array RAMs, then raises done.
module key_mix #(
  parameter int unsigned W = 32,
  parameter int unsigned C = 4,
  parameter int unsigned R = 12,
  localparam int unsigned T   = 2 * (R + 1),
  localparam int unsigned N   = 3 * ((T > C) ? T : C),
  localparam int unsigned SAW = $clog2(T),
  localparam int unsigned LAW = $clog2(C)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic [SAW-1:0] S_address,
  input  logic [W-1:0]   S_rdata,
  output logic [W-1:0]   S_wdata,
  output logic           S_we,
  output logic [LAW-1:0] L_address,
  input  logic [W-1:0]   L_rdata,
  output logic [W-1:0]   L_wdata,
  output logic           L_we,
  output logic           done
);

  localparam int unsigned RW = $clog2(W);
  localparam int unsigned KW = $clog2(N + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_CALC_A,
    ST_CALC_B,
    ST_UPDATE,
    ST_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   s_val_q, s_val_d;
  logic [W-1:0]   l_val_q, l_val_d;
  logic [SAW-1:0] i_q, i_d;
  logic [LAW-1:0] j_q, j_d;
  logic [KW-1:0]  k_q, k_d;
  logic [SAW-1:0] s_addr_q, s_addr_d;
  logic [LAW-1:0] l_addr_q, l_addr_d;
  logic [W-1:0]   s_wdata_q, s_wdata_d;
  logic [W-1:0]   l_wdata_q, l_wdata_d;
  logic           s_we_q, s_we_d;
  logic           l_we_q, l_we_d;
  logic           done_q, done_d;

  logic [W-1:0]   sum_a;
  logic [W-1:0]   sum_b;
  logic [W-1:0]   ab_sum;
  logic [W-1:0]   new_a;
  logic [W-1:0]   new_b;

  // Rotate left by the low log2(W) bits; amount 0 returns x unchanged.
  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [RW-1:0] amt);
    logic [2*W-1:0] t;
    t = {x, x} << amt;
    return t[2*W-1:W];
  endfunction

  // In CALC_B a_q already holds the freshly written A.
  always_comb begin
    sum_a  = s_val_q + a_q + b_q;
    new_a  = rotl(sum_a, RW'(3));
    ab_sum = a_q + b_q;
    sum_b  = l_val_q + ab_sum;
    new_b  = rotl(sum_b, ab_sum[RW-1:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      s_val_q   <= '0;
      l_val_q   <= '0;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      s_addr_q  <= '0;
      l_addr_q  <= '0;
      s_wdata_q <= '0;
      l_wdata_q <= '0;
      s_we_q    <= 1'b0;
      l_we_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      s_val_q   <= s_val_d;
      l_val_q   <= l_val_d;
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      s_addr_q  <= s_addr_d;
      l_addr_q  <= l_addr_d;
      s_wdata_q <= s_wdata_d;
      l_wdata_q <= l_wdata_d;
      s_we_q    <= s_we_d;
      l_we_q    <= l_we_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    s_val_d   = s_val_q;
    l_val_d   = l_val_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    s_addr_d  = s_addr_q;
    l_addr_d  = l_addr_q;
    s_wdata_d = s_wdata_q;
    l_wdata_d = l_wdata_q;
    s_we_d    = s_we_q;
    l_we_d    = l_we_q;
    done_d    = done_q;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        s_addr_d = i_q;
        l_addr_d = j_q;
        s_we_d   = 1'b0;
        l_we_d   = 1'b0;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        s_val_d = S_rdata;
        l_val_d = L_rdata;
        state_d = ST_CALC_A;
      end
      ST_CALC_A: begin
        a_d       = new_a;
        s_wdata_d = new_a;
        s_we_d    = 1'b1;
        state_d   = ST_CALC_B;
      end
      ST_CALC_B: begin
        s_we_d    = 1'b0;
        b_d       = new_b;
        l_wdata_d = new_b;
        l_we_d    = 1'b1;
        state_d   = ST_UPDATE;
      end
      ST_UPDATE: begin
        l_we_d = 1'b0;
        i_d    = (i_q == SAW'(T - 1)) ? '0 : i_q + SAW'(1);
        j_d    = (j_q == LAW'(C - 1)) ? '0 : j_q + LAW'(1);
        k_d    = k_q + KW'(1);
        if (k_q == KW'(N - 1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DONE: begin
        s_we_d = 1'b0;
        l_we_d = 1'b0;
        done_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign S_address = s_addr_q;
  assign S_wdata   = s_wdata_q;
  assign S_we      = s_we_q;
  assign L_address = l_addr_q;
  assign L_wdata   = l_wdata_q;
  assign L_we      = l_we_q;
  assign done      = done_q;

endmodule
